// File: rtl/hash_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
// Shared types for the hash scoreboard: request opcodes, response status codes,
// per-slot state, FSM state encoding and small sizing helpers.
// -----------------------------------------------------------------------------
package scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_OP_INSERT = 2'd0,
    SB_OP_LOOKUP = 2'd1,
    SB_OP_DELETE = 2'd2
  } sb_op_e;

  typedef enum logic [1:0] {
    SB_ST_OK        = 2'd0,
    SB_ST_NOT_FOUND = 2'd1,
    SB_ST_DUPLICATE = 2'd2,
    SB_ST_FULL      = 2'd3
  } sb_status_e;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_VALID = 2'd1,
    SLOT_TOMB  = 2'd2
  } sb_slot_state_e;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_PROBE = 2'd1,
    FSM_RESP  = 2'd2
  } sb_fsm_e;

  localparam int unsigned SB_DEPTH_DEF  = 8;
  localparam int unsigned SB_KEY_W_DEF  = 16;
  localparam int unsigned SB_VAL_W_DEF  = 4;

  // Width of one packed slot {state, key, val}.
  function automatic int unsigned sb_slot_w(input int unsigned key_w,
                                            input int unsigned val_w);
    return 2 + key_w + val_w;
  endfunction

endpackage

// File: rtl/hash_scoreboard_slot_array.sv
// -----------------------------------------------------------------------------
// hash_sb_slot_array
// Register storage for the scoreboard slots. Each slot holds a state
// (EMPTY/VALID/TOMB), a key and a value.
// Ports:
//   i_clk, i_rstn      clock, asynchronous active-low reset (all slots EMPTY)
//   i_bulk_clear       synchronous: every slot becomes EMPTY on the next edge
//   i_rd_idx           combinational read address
//   o_rd_state/key/val slot contents at i_rd_idx
//   i_wr_en/idx/state/key/val  synchronous single-slot write
// Bulk clear takes priority over a single-slot write in the same cycle.
// -----------------------------------------------------------------------------
module hash_sb_slot_array
  import scoreboard_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 4,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_bulk_clear,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output sb_slot_state_e       o_rd_state,
  output logic [KEY_WIDTH-1:0] o_rd_key,
  output logic [VAL_WIDTH-1:0] o_rd_val,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  sb_slot_state_e       i_wr_state,
  input  logic [KEY_WIDTH-1:0] i_wr_key,
  input  logic [VAL_WIDTH-1:0] i_wr_val
);

  sb_slot_state_e       state_q [DEPTH];
  logic [KEY_WIDTH-1:0] key_q   [DEPTH];
  logic [VAL_WIDTH-1:0] val_q   [DEPTH];

  assign o_rd_state = state_q[i_rd_idx];
  assign o_rd_key   = key_q[i_rd_idx];
  assign o_rd_val   = val_q[i_rd_idx];

  // Slot state is the only thing that must be reset: key/val of a non-VALID
  // slot are never looked at.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_EMPTY;
    end else if (i_bulk_clear) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_EMPTY;
    end else if (i_wr_en) begin
      state_q[i_wr_idx] <= i_wr_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      key_q[i_wr_idx] <= i_wr_key;
      val_q[i_wr_idx] <= i_wr_val;
    end
  end

endmodule

// File: rtl/hash_scoreboard.sv
// -----------------------------------------------------------------------------
// hash_scoreboard
// Key->value map in registers, open addressing with linear probing and
// tombstone deletion. One request at a time: IDLE -> PROBE (one slot per
// cycle) -> RESP (one-cycle response pulse) -> IDLE.
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_clear                  (only with HASH_SB_CLEAR_EN) synchronous flush
//   i_req_valid/o_req_ready  request handshake, ready only in IDLE
//   i_req_op/key/val         INSERT / LOOKUP / DELETE, sampled at acceptance
//   o_rsp_valid              one-cycle response pulse
//   o_rsp_status, o_rsp_val  result; value only on LOOKUP/DELETE OK, else 0
//   o_count                  number of VALID slots
// Optional feature macro: HASH_SB_CLEAR_EN adds i_clear.
// -----------------------------------------------------------------------------
module hash_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
`ifdef HASH_SB_CLEAR_EN
  input  logic                     i_clear,
`endif
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [1:0]               i_req_op,
  input  logic [KEY_WIDTH-1:0]     i_req_key,
  input  logic [VAL_WIDTH-1:0]     i_req_val,
  output logic                     o_rsp_valid,
  output logic [1:0]               o_rsp_status,
  output logic [VAL_WIDTH-1:0]     o_rsp_val,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic clear_req;
`ifdef HASH_SB_CLEAR_EN
  assign clear_req = i_clear;
`else
  assign clear_req = 1'b0;
`endif

  sb_fsm_e              fsm_q;
  sb_op_e               op_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [VAL_WIDTH-1:0] val_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     probes_q;
  logic                 tomb_seen_q;
  logic [IDX_W-1:0]     tomb_idx_q;
  logic [CNT_W-1:0]     count_q;
  logic                 rsp_valid_q;
  sb_status_e           rsp_status_q;
  logic [VAL_WIDTH-1:0] rsp_val_q;

  sb_slot_state_e       rd_state;
  logic [KEY_WIDTH-1:0] rd_key;
  logic [VAL_WIDTH-1:0] rd_val;

  logic                 accept;
  logic                 term;
  sb_status_e           status_d;
  logic [VAL_WIDTH-1:0] rsp_val_d;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  sb_slot_state_e       wr_state;
  logic                 cnt_inc;
  logic                 cnt_dec;
  logic                 cleanup;
  logic                 hit;
  logic                 tomb_here;
  logic                 last_probe;
  logic [IDX_W-1:0]     ins_idx;

  assign o_req_ready  = (fsm_q == FSM_IDLE);
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_status = rsp_status_q;
  assign o_rsp_val    = rsp_val_q;
  assign o_count      = count_q;

  assign accept     = (fsm_q == FSM_IDLE) && i_req_valid && !clear_req;
  assign hit        = (rd_state == SLOT_VALID) && (rd_key == key_q);
  assign tomb_here  = (rd_state == SLOT_TOMB);
  assign last_probe = (probes_q == IDX_W'(DEPTH - 1));
  // An INSERT reuses the first tombstone on its probe path; if none was seen
  // before this slot, the current slot is the target (EMPTY, or a TOMB on the
  // final probe).
  assign ins_idx    = tomb_seen_q ? tomb_idx_q : idx_q;

  // Probe decision for the slot at idx_q; any slot write happens on the
  // terminating edge only.
  always_comb begin
    term      = 1'b0;
    status_d  = SB_ST_OK;
    rsp_val_d = '0;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    wr_state  = SLOT_VALID;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cleanup   = 1'b0;
    if (fsm_q == FSM_PROBE) begin
      if (op_q == SB_OP_INSERT) begin
        if (hit) begin
          term     = 1'b1;
          status_d = SB_ST_DUPLICATE;
        end else if (rd_state == SLOT_EMPTY || last_probe) begin
          term = 1'b1;
          if (rd_state == SLOT_EMPTY || tomb_seen_q || tomb_here) begin
            wr_en   = 1'b1;
            wr_idx  = ins_idx;
            cnt_inc = 1'b1;
          end else begin
            status_d = SB_ST_FULL;
          end
        end
      end else begin
        if (hit) begin
          term      = 1'b1;
          rsp_val_d = rd_val;
          if (op_q == SB_OP_DELETE) begin
            wr_en    = 1'b1;
            wr_state = SLOT_TOMB;
            cnt_dec  = 1'b1;
            // Last live entry gone: flush all tombstones so later probes
            // stop at the home slot again.
            cleanup  = (count_q == CNT_W'(1));
          end
        end else if (rd_state == SLOT_EMPTY || last_probe) begin
          term     = 1'b1;
          status_d = SB_ST_NOT_FOUND;
        end
      end
    end
  end

  hash_sb_slot_array #(
    .DEPTH     (DEPTH),
    .KEY_WIDTH (KEY_WIDTH),
    .VAL_WIDTH (VAL_WIDTH),
    .IDX_W     (IDX_W)
  ) u_slots (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_bulk_clear (clear_req | cleanup),
    .i_rd_idx     (idx_q),
    .o_rd_state   (rd_state),
    .o_rd_key     (rd_key),
    .o_rd_val     (rd_val),
    .i_wr_en      (wr_en),
    .i_wr_idx     (wr_idx),
    .i_wr_state   (wr_state),
    .i_wr_key     (key_q),
    .i_wr_val     (val_q)
  );

  // Request payload is only meaningful after acceptance.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      key_q <= i_req_key;
      val_q <= i_req_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fsm_q        <= FSM_IDLE;
      op_q         <= SB_OP_INSERT;
      idx_q        <= '0;
      probes_q     <= '0;
      tomb_seen_q  <= 1'b0;
      tomb_idx_q   <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= SB_ST_OK;
      rsp_val_q    <= '0;
    end else if (clear_req) begin
      fsm_q       <= FSM_IDLE;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (accept) begin
            op_q        <= sb_op_e'(i_req_op);
            idx_q       <= i_req_key[IDX_W-1:0];
            probes_q    <= '0;
            tomb_seen_q <= 1'b0;
            fsm_q       <= FSM_PROBE;
          end
        end
        FSM_PROBE: begin
          if (term) begin
            fsm_q        <= FSM_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= status_d;
            rsp_val_q    <= rsp_val_d;
            if (cnt_inc) count_q <= count_q + CNT_W'(1);
            if (cnt_dec) count_q <= count_q - CNT_W'(1);
          end else begin
            // DEPTH is a power of two, so the index wraps naturally.
            idx_q    <= idx_q + IDX_W'(1);
            probes_q <= probes_q + IDX_W'(1);
            if (tomb_here && !tomb_seen_q) begin
              tomb_seen_q <= 1'b1;
              tomb_idx_q  <= idx_q;
            end
          end
        end
        FSM_RESP: begin
          rsp_valid_q <= 1'b0;
          fsm_q       <= FSM_IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          fsm_q       <= FSM_IDLE;
        end
      endcase
    end
  end

endmodule
